// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a request-to-send, shifts out start/d0..d7/parity/stop
// on device-generated falling clock edges, checks the device ACK and waits for
// the bus to return idle. Both lines are driven open-drain via pull-low enables.
// Optional build macro PS2_TX_ECHO_CHECK_EN: compare the line against the driven
// data/parity bit on each rising clock edge and abort on contention.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    // Odd parity bit: total number of ones across data and parity is odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t           state_r, state_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx, cnt_inc_s;
    logic [3:0]       idx_r, idx_nx;
    logic [10:0]      frame_r, frame_nx;
    logic             done_nx, err_nx;
    logic             clk_oe_nx, data_oe_nx, ready_nx;
    logic             timeout_s, echo_bad_s;

    logic             clk_meta_r, clk_sync_r, clk_prev_r, clk_fe_r;
    logic             data_meta_r, data_sync_r;

    // Two-flop synchronizers on both lines plus a registered falling-edge strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_prev_r  <= 1'b1;
            clk_fe_r    <= 1'b0;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk_in;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            clk_fe_r    <= clk_prev_r & ~clk_sync_r;
            data_meta_r <= ps2_data_in;
            data_sync_r <= data_meta_r;
        end
    end

`ifdef PS2_TX_ECHO_CHECK_EN
    logic clk_re_r;

    // Registered rising-edge strobe, only needed for the echo comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_re_r <= 1'b0;
        end else begin
            clk_re_r <= ~clk_prev_r & clk_sync_r;
        end
    end
`endif

    // Next-state, counter, bit index and registered-output next values.
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        idx_nx     = idx_r;
        frame_nx   = frame_r;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        cnt_inc_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        timeout_s  = (cnt_inc_s == TMO_LIMIT);
        echo_bad_s = 1'b0;
`ifdef PS2_TX_ECHO_CHECK_EN
        if ((state_r == ST_SEND) && clk_re_r && (idx_r >= 4'd1) && (idx_r <= 4'd9)
            && (data_sync_r != frame_r[idx_r])) begin
            echo_bad_s = 1'b1;
        end else begin
            echo_bad_s = 1'b0;
        end
`endif

        case (state_r)
            ST_IDLE: begin
                if (tx_valid) begin
                    frame_nx = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                    cnt_nx   = {CNT_W{1'b0}};
                    idx_nx   = 4'd0;
                    state_nx = ST_INHIBIT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (cnt_r == INH_LAST) begin
                    cnt_nx   = {CNT_W{1'b0}};
                    state_nx = ST_REQ;
                end else begin
                    cnt_nx = cnt_inc_s;
                end
            end
            ST_REQ: begin
                cnt_nx = cnt_inc_s;
                if (timeout_s) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    idx_nx   = 4'd0;
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_nx = cnt_inc_s;
                if (timeout_s || echo_bad_s) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (clk_fe_r) begin
                    idx_nx = idx_r + 4'd1;
                    // The fe that presents the stop bit hands over to the ACK phase.
                    if (idx_r == 4'd9) begin
                        state_nx = ST_ACK;
                    end else begin
                        state_nx = ST_SEND;
                    end
                end else begin
                    state_nx = ST_SEND;
                end
            end
            ST_ACK: begin
                cnt_nx = cnt_inc_s;
                if (timeout_s) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (clk_fe_r) begin
                    if (data_sync_r == 1'b0) begin
                        state_nx = ST_WAIT_IDLE;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end else begin
                    state_nx = ST_ACK;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_nx = cnt_inc_s;
                if (timeout_s) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (clk_sync_r && data_sync_r) begin
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (state_nx == ST_IDLE) begin
            cnt_nx = {CNT_W{1'b0}};
        end else begin
            cnt_nx = cnt_nx;
        end

        // Outputs are registered from the next state so they line up with state_r.
        clk_oe_nx  = (state_nx == ST_INHIBIT) || (state_nx == ST_REQ);
        data_oe_nx = (state_nx == ST_REQ) || ((state_nx == ST_SEND) && !frame_nx[idx_nx]);
        ready_nx   = (state_nx == ST_IDLE);
    end

    // State register and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= 4'd0;
            frame_r     <= 11'd0;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cnt_r       <= cnt_nx;
            idx_r       <= idx_nx;
            frame_r     <= frame_nx;
            tx_ready    <= ready_nx;
            tx_busy     <= ~ready_nx;
            tx_done     <= done_nx;
            tx_err      <= err_nx;
            ps2_clk_oe  <= clk_oe_nx;
            ps2_data_oe <= data_oe_nx;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH = 24;
    localparam int TMO = 1500;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;

    int checks = 0;
    int passes = 0;

    // device model results
    logic samp [0:10];
    int   nsamp, nfe, dev_t, re_mark, err_mark;
    logic aborted;

    // monitor results
    int   err_hi = 0, done_hi = 0, both_hi = 0;
    logic prev_err = 1'b0, prev_done = 1'b0;
    logic ready_after_err = 1'b0, ready_after_done = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Counts high cycles of the status pulses and what tx_ready does afterwards.
    always @(negedge clk) begin
        if (tx_err === 1'b1) err_hi <= err_hi + 1;
        if (tx_done === 1'b1) done_hi <= done_hi + 1;
        if (tx_err === 1'b1 && tx_done === 1'b1) both_hi <= both_hi + 1;
        if (prev_err) ready_after_err <= tx_ready;
        if (prev_done) ready_after_done <= tx_ready;
        prev_err  <= tx_err;
        prev_done <= tx_done;
    end

    // Reference: bits a device sees on the line, in time order (index 0 = start).
    function automatic logic [10:0] model_bits(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    function automatic logic [10:0] got_bits();
        logic [10:0] v;
        for (int i = 0; i < 11; i++) v[i] = samp[i];
        return v;
    endfunction

    task automatic dwait(input int n);
        for (int i = 0; i < n; i++) begin
            if (!aborted) begin
                @(negedge clk);
                dev_t++;
                if (tx_err === 1'b1) begin
                    aborted  = 1'b1;
                    err_mark = dev_t;
                end
            end
        end
    endtask

    // Device: waits for request-to-send, clocks up to max_fe falling edges,
    // samples on rising edges, optionally pulls data low during bit k=contend_k.
    task automatic device_run(input logic do_ack, input int contend_k, input int max_fe);
        int n;
        aborted = 1'b0; nsamp = 0; nfe = 0; dev_t = 0; re_mark = -1; err_mark = -1;
        for (int i = 0; i < 11; i++) samp[i] = 1'bx;
        n = 0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0 && ps2_clk_oe === 1'b0) && n < INH + 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= INH + 100) begin
            aborted = 1'b1;
            return;
        end
        samp[0] = ps2_data_in;
        nsamp = 1;
        for (int k = 1; k <= max_fe; k++) begin
            if (aborted) break;
            if (k == 11) dev_data_low = do_ack;
            dwait(H);
            if (aborted) break;
            dev_clk_low = 1'b1;
            nfe = k;
            if (k == max_fe && k < 11) break;
            if (k == contend_k) begin
                dwait(H / 2);
                dev_data_low = 1'b1;
                dwait(H - H / 2);
            end else begin
                dwait(H);
            end
            if (k <= 10) begin
                samp[k] = ps2_data_in;
                nsamp = k + 1;
            end
            dev_clk_low = 1'b0;
            re_mark = dev_t;
            if (k == contend_k || k == 11) begin
                dwait(H / 2);
                dev_data_low = 1'b0;
            end
        end
        if (aborted) begin
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (tx_done !== 1'b1 && tx_err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe} !== 6'b100000)
            $display("FAIL reset_outputs got=%b want=100000",
                     {tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe});
        else passes++;
    endtask

    task automatic test_f4();
        int n, d0;
        d0 = done_hi;
        start_tx(8'hF4);
        checks++;
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1 || ps2_clk_oe !== 1'b1)
            $display("FAIL f4_accept ready=%b busy=%b clk_oe=%b want 0 1 1", tx_ready, tx_busy, ps2_clk_oe);
        else passes++;
        device_run(1'b1, -1, 11);
        wait_end(n);
        checks++;
        if (tx_done !== 1'b1 || tx_ready !== 1'b1)
            $display("FAIL f4_done done=%b ready=%b want 1 1", tx_done, tx_ready);
        else passes++;
        checks++;
        if (got_bits() !== 11'b10111101000)
            $display("FAIL f4_bits got=%b want=%b", got_bits(), 11'b10111101000);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (done_hi - d0 !== 1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
            $display("FAIL f4_release done_cycles=%0d clk_oe=%b data_oe=%b want 1 0 0",
                     done_hi - d0, ps2_clk_oe, ps2_data_oe);
        else passes++;
    endtask

    task automatic test_ff_inhibit();
        int n, m;
        start_tx(8'hFF);
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < INH + 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== INH || ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b1)
            $display("FAIL ff_inhibit cycles=%0d want=%0d (clk_oe=%b data_oe=%b at req)",
                     n, INH, ps2_clk_oe, ps2_data_oe);
        else passes++;
        device_run(1'b1, -1, 11);
        wait_end(m);
        checks++;
        if (tx_done !== 1'b1 || samp[9] !== 1'b1)
            $display("FAIL ff_parity done=%b par=%b want 1 1", tx_done, samp[9]);
        else passes++;
        checks++;
        if (got_bits() !== model_bits(8'hFF))
            $display("FAIL ff_bits got=%b want=%b", got_bits(), model_bits(8'hFF));
        else passes++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nack();
        int n, e0, d0;
        e0 = err_hi; d0 = done_hi;
        start_tx(8'h3C);
        device_run(1'b0, -1, 11);
        checks++;
        if (tx_err !== 1'b1 || nfe !== 11)
            $display("FAIL nack_err err=%b fe_count=%0d want 1 11", tx_err, nfe);
        else passes++;
        repeat (4) @(negedge clk);
        checks++;
        if (err_hi - e0 !== 1 || done_hi !== d0 || ready_after_err !== 1'b1)
            $display("FAIL nack_pulse err_cycles=%0d done_cycles=%0d ready_next=%b want 1 0 1",
                     err_hi - e0, done_hi - d0, ready_after_err);
        else passes++;
    endtask

    task automatic test_timeout();
        int n;
        start_tx(8'hA5);
        n = 0;
        while (!(ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) && n < INH + 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx_err !== 1'b1 && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== TMO)
            $display("FAIL timeout_latency got=%0d want=%0d", n, TMO);
        else passes++;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1)
            $display("FAIL timeout_release clk_oe=%b data_oe=%b ready=%b want 0 0 1",
                     ps2_clk_oe, ps2_data_oe, tx_ready);
        else passes++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        start_tx(8'hF4);
        device_run(1'b1, -1, 5);
        repeat (6) @(negedge clk);
        checks++;
        if (tx_busy !== 1'b1 || nfe !== 5)
            $display("FAIL rstmid_busy busy=%b fe_count=%0d want 1 5", tx_busy, nfe);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || tx_busy !== 1'b0)
            $display("FAIL rstmid_release clk_oe=%b data_oe=%b ready=%b busy=%b want 0 0 1 0",
                     ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy);
        else passes++;
        rst = 1'b0;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (10) @(negedge clk);
        start_tx(8'hF4);
        device_run(1'b1, -1, 11);
        wait_end(n);
        checks++;
        if (tx_done !== 1'b1 || got_bits() !== model_bits(8'hF4))
            $display("FAIL rstmid_resend done=%b bits=%b want 1 %b", tx_done, got_bits(), model_bits(8'hF4));
        else passes++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_contention();
        int e0, d0;
        e0 = err_hi; d0 = done_hi;
        start_tx(8'hF4);
        device_run(1'b0, 3, 11);
        repeat (4) @(negedge clk);
`ifdef PS2_TX_ECHO_CHECK_EN
        checks++;
        if (nfe !== 3 || err_mark - re_mark < 1 || err_mark - re_mark > 8)
            $display("FAIL echo_err fe_count=%0d latency=%0d want fe 3, latency 1..8",
                     nfe, err_mark - re_mark);
        else passes++;
`else
        checks++;
        if (nfe !== 11 || samp[3] !== 1'b0)
            $display("FAIL noecho_err fe_count=%0d contended_bit=%b want 11 0", nfe, samp[3]);
        else passes++;
`endif
        checks++;
        if (err_hi - e0 !== 1 || done_hi !== d0)
            $display("FAIL contention_pulse err_cycles=%0d done_cycles=%0d want 1 0",
                     err_hi - e0, done_hi - d0);
        else passes++;
    endtask

    task automatic test_random();
        int n;
        logic [7:0] b;
        for (int r = 0; r < 4; r++) begin
            b = 8'($urandom_range(0, 255));
            start_tx(b);
            device_run(1'b1, -1, 11);
            wait_end(n);
            checks++;
            if (tx_done !== 1'b1 || got_bits() !== model_bits(b))
                $display("FAIL random_%0d byte=%h done=%b bits=%b want 1 %b",
                         r, b, tx_done, got_bits(), model_bits(b));
            else passes++;
            repeat (3) @(negedge clk);
        end
        checks++;
        if (both_hi !== 0)
            $display("FAIL done_err_overlap cycles=%0d want 0", both_hi);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_f4();
        test_ff_inhibit();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_contention();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
